// File: rtl/adsr_envelope_if.sv
// ---------------------------------------------------------------------------
// adsr_envelope_if
//   Bundles the control, sample and status signals of the ADSR envelope stage.
//   master : the controller / upstream side (drives gate, rates, sample_in)
//   slave  : the envelope stage itself (drives sample_out, envelope, active)
//   Signals:
//     gate           note on (1) / note off (0)
//     attack_rate    clocks per attack step, minus 1
//     decay_rate     clocks per decay step, minus 1
//     sustain_level  sustain level
//     release_rate   clocks per release step, minus 1
//     sample_in      unsigned sample from the square generator
//     sample_out     enveloped sample, registered
//     envelope       current envelope level, registered
//     active         high whenever the envelope FSM is not idle
// ---------------------------------------------------------------------------
interface adsr_envelope_if #(
  parameter int resolution_bits = 8,
  parameter int env_bits        = 8,
  parameter int rate_width      = 16
);
  logic                       gate;
  logic [rate_width-1:0]      attack_rate;
  logic [rate_width-1:0]      decay_rate;
  logic [env_bits-1:0]        sustain_level;
  logic [rate_width-1:0]      release_rate;
  logic [resolution_bits-1:0] sample_in;
  logic [resolution_bits-1:0] sample_out;
  logic [env_bits-1:0]        envelope;
  logic                       active;

  modport master (
    output gate, attack_rate, decay_rate, sustain_level, release_rate, sample_in,
    input  sample_out, envelope, active
  );

  modport slave (
    input  gate, attack_rate, decay_rate, sustain_level, release_rate, sample_in,
    output sample_out, envelope, active
  );
endinterface

// File: rtl/adsr_envelope.sv
// ---------------------------------------------------------------------------
// adsr_envelope
//   Applies an ADSR amplitude envelope to the unsigned sample stream of the
//   square-wave generator. A 5-state FSM (IDLE/ATTACK/DECAY/SUSTAIN/RELEASE)
//   driven by the gate produces the envelope level; the sample is multiplied
//   by that level and the top resolution_bits of the product are registered.
//   Ports:
//     clk      system clock
//     reset_n  asynchronous active-low reset (aborts any note immediately)
//     bus      adsr_envelope_if slave modport (controls, sample in/out, status)
//   Build option:
//     ENV_EXP_RELEASE_EN  when defined, the release step is envelope>>3
//                         (minimum 1), approximating an exponential tail;
//                         otherwise the release is linear, one per step.
// ---------------------------------------------------------------------------
module adsr_envelope #(
  parameter int resolution_bits = 8,
  parameter int env_bits        = 8,
  parameter int rate_width      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  adsr_envelope_if.slave   bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ATTACK  = 3'd1;
  localparam logic [2:0] S_DECAY   = 3'd2;
  localparam logic [2:0] S_SUSTAIN = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [env_bits-1:0] ENV_MAX = '1;
  localparam int                  PROD_W  = resolution_bits + env_bits;

  logic [2:0]                 r_state;
  logic [env_bits-1:0]        r_env;
  logic [rate_width-1:0]      r_rate_cnt;
  logic [resolution_bits-1:0] r_sample_out;
  logic [rate_width-1:0]      w_rate;
  logic                       w_tick;

  // Saturating increment: holds at full scale instead of wrapping.
  function automatic logic [env_bits-1:0] f_env_inc(input logic [env_bits-1:0] v);
    return (v == ENV_MAX) ? v : v + env_bits'(1);
  endfunction

  // Saturating decrement by step: clamps at zero instead of wrapping.
  function automatic logic [env_bits-1:0] f_env_dec(input logic [env_bits-1:0] v,
                                                     input logic [env_bits-1:0] step);
    return (v > step) ? v - step : '0;
  endfunction

  function automatic logic [env_bits-1:0] f_release_step(input logic [env_bits-1:0] v);
    logic [env_bits-1:0] s;
`ifdef ENV_EXP_RELEASE_EN
    s = v >> 3;
    if (s == '0) s = env_bits'(1);
`else
    s = env_bits'(1);
    if (v == '0) s = env_bits'(1);
`endif
    return s;
  endfunction

  // Unsigned product, keep the upper resolution_bits (255*255 -> 254).
  function automatic logic [resolution_bits-1:0] f_scale(input logic [resolution_bits-1:0] s,
                                                         input logic [env_bits-1:0]        e);
    logic [PROD_W-1:0] p;
    p = PROD_W'(s) * PROD_W'(e);
    return p[PROD_W-1:env_bits];
  endfunction

  // Prescaler reload value for whichever ramp state is active.
  always_comb begin
    w_rate = '0;
    case (r_state)
      S_ATTACK:  w_rate = bus.attack_rate;
      S_DECAY:   w_rate = bus.decay_rate;
      S_RELEASE: w_rate = bus.release_rate;
      default:   w_rate = '0;
    endcase
  end

  assign w_tick = (r_rate_cnt == w_rate);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_env        <= '0;
      r_rate_cnt   <= '0;
      r_sample_out <= '0;
    end else begin
      // Output stage: product of the envelope value held during this clock.
      r_sample_out <= f_scale(bus.sample_in, r_env);

      case (r_state)
        S_IDLE: begin
          if (bus.gate) begin
            r_state    <= S_ATTACK;
            r_rate_cnt <= '0;
          end
        end

        S_ATTACK: begin
          if (!bus.gate) begin
            r_state    <= S_RELEASE;
            r_rate_cnt <= '0;
          end else if (w_tick) begin
            r_rate_cnt <= '0;
            r_env      <= f_env_inc(r_env);
            // The step that lands on (or is already at) full scale ends the attack.
            if (r_env >= ENV_MAX - env_bits'(1)) r_state <= S_DECAY;
          end else begin
            r_rate_cnt <= r_rate_cnt + rate_width'(1);
          end
        end

        S_DECAY: begin
          if (!bus.gate) begin
            r_state    <= S_RELEASE;
            r_rate_cnt <= '0;
          end else if (r_env <= bus.sustain_level) begin
            // Level comparison takes priority over any step this clock.
            r_state    <= S_SUSTAIN;
            r_rate_cnt <= '0;
          end else if (w_tick) begin
            r_rate_cnt <= '0;
            r_env      <= f_env_dec(r_env, env_bits'(1));
          end else begin
            r_rate_cnt <= r_rate_cnt + rate_width'(1);
          end
        end

        S_SUSTAIN: begin
          if (!bus.gate) begin
            r_state    <= S_RELEASE;
            r_rate_cnt <= '0;
          end else begin
            r_env <= bus.sustain_level;
          end
        end

        S_RELEASE: begin
          if (bus.gate) begin
            // Retrigger: attack resumes from the current level.
            r_state    <= S_ATTACK;
            r_rate_cnt <= '0;
          end else if (w_tick) begin
            r_rate_cnt <= '0;
            r_env      <= f_env_dec(r_env, f_release_step(r_env));
            if (r_env <= f_release_step(r_env)) r_state <= S_IDLE;
          end else begin
            r_rate_cnt <= r_rate_cnt + rate_width'(1);
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_rate_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.sample_out = r_sample_out;
  assign bus.envelope   = r_env;
  assign bus.active     = (r_state != S_IDLE);

endmodule
